// File: rtl/game_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_pkg : phase, player-state and winner encodings for the match logic
// Revision : 1.0
// ---------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [2:0] {
    PH_IDLE       = 3'd0,
    PH_INTRO      = 3'd1,
    PH_FIGHT      = 3'd2,
    PH_KO         = 3'd3,
    PH_MATCH_OVER = 3'd4
  } phase_t;

  localparam logic [3:0] S_HITSTUN = 4'd9;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  function automatic logic [2:0] sat_dec3(input logic [2:0] v, input logic en);
    return (en && (v != 3'd0)) ? v - 3'd1 : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hit_edge_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hit_edge_detect : flags the cycle a player's state first enters hitstun
// Revision        : 1.0
// ---------------------------------------------------------------------------
module hit_edge_detect
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] player_state,
  output logic       hit
);

  logic hs;
  logic hs_q;

  assign hs = (player_state == S_HITSTUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hs_q <= 1'b0;
    else      hs_q <= hs;
  end

  assign hit = hs & ~hs_q;

endmodule
`default_nettype wire

// File: rtl/match_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// match_controller : best-of-N match sequencer (health, timer, round tally)
// Revision         : 1.0
// ---------------------------------------------------------------------------
module match_controller
  import game_pkg::*;
#(
  parameter int HEALTH_MAX    = 3,
  parameter int ROUNDS_TO_WIN = 2,
  parameter int ROUND_TIME    = 99,
  parameter int TICKS_PER_SEC = 60,
  parameter int INTRO_FRAMES  = 90,
  parameter int KO_FRAMES     = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [3:0] player1_state,
  input  logic [3:0] player2_state,
  output logic [2:0] phase,
  output logic       fight_enable,
  output logic [2:0] player1_health,
  output logic [2:0] player2_health,
  output logic [1:0] player1_rounds,
  output logic [1:0] player2_rounds,
  output logic [6:0] round_timer,
  output logic [1:0] round_winner,
  output logic [1:0] match_winner
);

  localparam int FRAME_MAX = (INTRO_FRAMES > KO_FRAMES) ? INTRO_FRAMES : KO_FRAMES;
  localparam int FW = $clog2(FRAME_MAX + 1);
  localparam int TW = $clog2(TICKS_PER_SEC + 1);

  localparam logic [FW-1:0] INTRO_LAST = FW'(INTRO_FRAMES - 1);
  localparam logic [FW-1:0] KO_LAST    = FW'(KO_FRAMES - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_SEC - 1);
  localparam logic [2:0]    HP_INIT    = 3'(HEALTH_MAX);
  localparam logic [6:0]    TIME_INIT  = 7'(ROUND_TIME);
  localparam logic [1:0]    WIN_CNT    = 2'(ROUNDS_TO_WIN);

  phase_t        state;
  logic [FW-1:0] frame_cnt;
  logic [TW-1:0] tick_cnt;

  logic hit1;
  logic hit2;
  logic ko_cond;
  logic p1_done;
  logic p2_done;
  logic ko_exit;
  logic go_intro;

  hit_edge_detect u_hit1 (
    .clk          (clk),
    .rst          (rst),
    .player_state (player1_state),
    .hit          (hit1)
  );

  hit_edge_detect u_hit2 (
    .clk          (clk),
    .rst          (rst),
    .player_state (player2_state),
    .hit          (hit2)
  );

  assign phase   = state;
  assign ko_cond = (player1_health == 3'd0) | (player2_health == 3'd0) | (round_timer == 7'd0);
  assign p1_done = (player1_rounds == WIN_CNT);
  assign p2_done = (player2_rounds == WIN_CNT);
  assign ko_exit = frame_tick && (frame_cnt == KO_LAST);

  // Every path into INTRO reloads the per-round registers the same way.
  always_comb begin
    go_intro = 1'b0;
    case (state)
      PH_IDLE:       go_intro = start;
      PH_KO:         go_intro = ko_exit && !p1_done && !p2_done;
      PH_MATCH_OVER: go_intro = start;
      default:       go_intro = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= PH_IDLE;
      fight_enable   <= 1'b0;
      player1_health <= HP_INIT;
      player2_health <= HP_INIT;
      player1_rounds <= 2'd0;
      player2_rounds <= 2'd0;
      round_timer    <= TIME_INIT;
      round_winner   <= WIN_NONE;
      match_winner   <= WIN_NONE;
      frame_cnt      <= '0;
      tick_cnt       <= '0;
    end else begin
      case (state)
        PH_INTRO: begin
          if (frame_tick) begin
            if (frame_cnt == INTRO_LAST) begin
              state        <= PH_FIGHT;
              fight_enable <= 1'b1;
              frame_cnt    <= '0;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end

        PH_FIGHT: begin
          if (ko_cond) begin
            // Hits arriving on the KO cycle are dropped: the round is decided.
            state        <= PH_KO;
            fight_enable <= 1'b0;
            frame_cnt    <= '0;
            if (player1_health > player2_health) begin
              round_winner   <= WIN_P1;
              player1_rounds <= player1_rounds + 2'd1;
            end else if (player2_health > player1_health) begin
              round_winner   <= WIN_P2;
              player2_rounds <= player2_rounds + 2'd1;
            end else begin
              round_winner <= WIN_DRAW;
            end
          end else begin
            player1_health <= sat_dec3(player1_health, hit1);
            player2_health <= sat_dec3(player2_health, hit2);
            if (frame_tick) begin
              if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                if (round_timer != 7'd0) round_timer <= round_timer - 7'd1;
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
          end
        end

        PH_KO: begin
          if (frame_tick) begin
            if (ko_exit) begin
              frame_cnt <= '0;
              if (p1_done) begin
                state        <= PH_MATCH_OVER;
                match_winner <= WIN_P1;
              end else if (p2_done) begin
                state        <= PH_MATCH_OVER;
                match_winner <= WIN_P2;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end

        PH_MATCH_OVER: begin
          if (start) begin
            player1_rounds <= 2'd0;
            player2_rounds <= 2'd0;
            round_winner   <= WIN_NONE;
            match_winner   <= WIN_NONE;
          end
        end

        default: ;
      endcase

      if (go_intro) begin
        state          <= PH_INTRO;
        fight_enable   <= 1'b0;
        player1_health <= HP_INIT;
        player2_health <= HP_INIT;
        round_timer    <= TIME_INIT;
        tick_cnt       <= '0;
        frame_cnt      <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_match_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_match_controller : directed bench for match_controller
// Revision            : 1.0
// ---------------------------------------------------------------------------
module tb_match_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       start;
  logic [3:0] player1_state;
  logic [3:0] player2_state;
  logic [2:0] phase;
  logic       fight_enable;
  logic [2:0] player1_health;
  logic [2:0] player2_health;
  logic [1:0] player1_rounds;
  logic [1:0] player2_rounds;
  logic [6:0] round_timer;
  logic [1:0] round_winner;
  logic [1:0] match_winner;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  match_controller dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .start          (start),
    .player1_state  (player1_state),
    .player2_state  (player2_state),
    .phase          (phase),
    .fight_enable   (fight_enable),
    .player1_health (player1_health),
    .player2_health (player2_health),
    .player1_rounds (player1_rounds),
    .player2_rounds (player2_rounds),
    .round_timer    (round_timer),
    .round_winner   (round_winner),
    .match_winner   (match_winner)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    cyc(n);
    frame_tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic hit(input bit p1, input bit p2);
    if (p1) player1_state = 4'd9;
    if (p2) player2_state = 4'd9;
    cyc(1);
  endtask

  task automatic release_both();
    player1_state = 4'd0;
    player2_state = 4'd0;
    cyc(1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_phase"},  8'(phase), 8'd0);
    check({tag, "_fe"},     8'(fight_enable), 8'd0);
    check({tag, "_h1"},     8'(player1_health), 8'd3);
    check({tag, "_h2"},     8'(player2_health), 8'd3);
    check({tag, "_r1"},     8'(player1_rounds), 8'd0);
    check({tag, "_r2"},     8'(player2_rounds), 8'd0);
    check({tag, "_timer"},  8'(round_timer), 8'd99);
    check({tag, "_rw"},     8'(round_winner), 8'd0);
    check({tag, "_mw"},     8'(match_winner), 8'd0);
  endtask

  initial begin
    rst = 1'b0;
    frame_tick = 1'b0;
    start = 1'b0;
    player1_state = 4'd0;
    player2_state = 4'd0;
    cyc(2);
    check_reset_values("rst");
    rst = 1'b1;
    cyc(1);

    // Round 1: P2 takes three hits
    pulse_start();
    check("intro_phase", 8'(phase), 8'd1);
    ticks(89);
    check("intro_hold", 8'(phase), 8'd1);
    ticks(1);
    check("fight_phase", 8'(phase), 8'd2);
    check("fight_fe", 8'(fight_enable), 8'd1);
    check("fight_h1", 8'(player1_health), 8'd3);
    check("fight_h2", 8'(player2_health), 8'd3);
    check("fight_timer", 8'(round_timer), 8'd99);
    hit(0, 1); check("p2_hit1", 8'(player2_health), 8'd2); release_both();
    hit(0, 1); check("p2_hit2", 8'(player2_health), 8'd1); release_both();
    hit(0, 1); check("p2_hit3", 8'(player2_health), 8'd0);
    check("p2_ko_pending", 8'(phase), 8'd2);
    release_both();
    check("ko1_phase", 8'(phase), 8'd3);
    check("ko1_rw", 8'(round_winner), 8'd1);
    check("ko1_r1", 8'(player1_rounds), 8'd1);
    check("ko1_fe", 8'(fight_enable), 8'd0);
    pulse_start();
    check("ko_start_ignored", 8'(phase), 8'd3);
    ticks(120);
    check("r2_intro", 8'(phase), 8'd1);
    check("r2_h2_reload", 8'(player2_health), 8'd3);

    // Round 2: hitstun held across INTRO->FIGHT, then a double KO
    player1_state = 4'd9;
    ticks(90);
    check("r2_fight", 8'(phase), 8'd2);
    cyc(2);
    check("held_no_hit", 8'(player1_health), 8'd3);
    player1_state = 4'd0; cyc(1);
    player1_state = 4'd9; cyc(1);
    check("reentry_hit", 8'(player1_health), 8'd2);
    release_both();
    hit(1, 0); check("p1_to_1", 8'(player1_health), 8'd1); release_both();
    hit(0, 1); release_both();
    hit(0, 1); check("p2_to_1", 8'(player2_health), 8'd1); release_both();
    hit(1, 1);
    check("dbl_h1", 8'(player1_health), 8'd0);
    check("dbl_h2", 8'(player2_health), 8'd0);
    release_both();
    check("dbl_phase", 8'(phase), 8'd3);
    check("dbl_rw", 8'(round_winner), 8'd3);
    check("dbl_r1", 8'(player1_rounds), 8'd1);
    check("dbl_r2", 8'(player2_rounds), 8'd0);
    ticks(120);
    check("r3_intro", 8'(phase), 8'd1);

    // Round 3: time-out with healths 3/2
    ticks(90);
    hit(0, 1); check("r3_h2", 8'(player2_health), 8'd2); release_both();
    ticks(59);
    check("timer_59", 8'(round_timer), 8'd99);
    ticks(1);
    check("timer_60", 8'(round_timer), 8'd98);
    ticks(5880);
    check("timer_zero", 8'(round_timer), 8'd0);
    check("timer_zero_phase", 8'(phase), 8'd2);
    cyc(1);
    check("to_phase", 8'(phase), 8'd3);
    check("to_rw", 8'(round_winner), 8'd1);
    check("to_r1", 8'(player1_rounds), 8'd2);
    ticks(119);
    check("ko_hold", 8'(phase), 8'd3);
    ticks(1);
    check("mo_phase", 8'(phase), 8'd4);
    check("mo_mw", 8'(match_winner), 8'd1);
    cyc(3);
    check("mo_hold", 8'(phase), 8'd4);
    check("mo_r1_hold", 8'(player1_rounds), 8'd2);
    pulse_start();
    check("restart_phase", 8'(phase), 8'd1);
    check("restart_r1", 8'(player1_rounds), 8'd0);
    check("restart_r2", 8'(player2_rounds), 8'd0);
    check("restart_mw", 8'(match_winner), 8'd0);
    check("restart_rw", 8'(round_winner), 8'd0);

    // Asynchronous reset in the middle of a fight
    ticks(90);
    hit(1, 0); check("pre_rst_h1", 8'(player1_health), 8'd2); release_both();
    ticks(60);
    check("pre_rst_timer", 8'(round_timer), 8'd98);
    #2 rst = 1'b0;
    #1;
    check_reset_values("async");
    cyc(1);
    rst = 1'b1;
    cyc(1);
    check("post_rst_idle", 8'(phase), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/match_controller.md
Name: match_controller

Overview:
- Sequences a best-of-N fighting match: intro, fight, KO and match-over phases.
- Owns both players' health registers and decrements health on hitstun entry, synchronous to clk.
- Runs the round timer and tallies rounds won.
- Sits between the two player state machines (hitstun reporting) and the HUD/renderer, and gates player input through fight_enable.

Parameters:
- HEALTH_MAX, 3: health reloaded at each round start (3-bit, 1..7).
- ROUNDS_TO_WIN, 2: rounds a player needs to win the match (2-bit, 1..3).
- ROUND_TIME, 99: round timer start value in seconds (7-bit, 1..99).
- TICKS_PER_SEC, 60: frame_tick pulses per timer second.
- INTRO_FRAMES, 90: frames spent in INTRO before FIGHT.
- KO_FRAMES, 120: frames spent in KO before the next round or match over.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- start  in  1  one-cycle pulse; starts a match from IDLE or MATCH_OVER
- player1_state  in  4  player 1 FSM state; 4'd9 = hitstun
- player2_state  in  4  player 2 FSM state; 4'd9 = hitstun
- phase  out  3  current phase: IDLE=0, INTRO=1, FIGHT=2, KO=3, MATCH_OVER=4
- fight_enable  out  1  high only in FIGHT
- player1_health  out  3  current health, player 1
- player2_health  out  3  current health, player 2
- player1_rounds  out  2  rounds won, player 1
- player2_rounds  out  2  rounds won, player 2
- round_timer  out  7  seconds remaining
- round_winner  out  2  last round result: 0 none, 1 P1, 2 P2, 3 draw
- match_winner  out  2  0 none, 1 P1, 2 P2; valid in MATCH_OVER

Behaviour:
- Reset (rst low, async) values:
  - phase=IDLE; fight_enable=0
  - healths=HEALTH_MAX; rounds=0
  - round_timer=ROUND_TIME
  - round_winner=0; match_winner=0
  - frame and second counters cleared; hitstun edge registers cleared to 0
- All outputs are registered.
- Hit detection:
  - hs_n = (playerN_state==4'd9), registered every cycle in every phase.
  - A hit is the rising edge of hs_n (hs_n & ~hs_n_q).
  - A hitstun held across the INTRO->FIGHT transition produces no hit.
- Hits are applied only in FIGHT when ko_cond is false:
  - health decrements by 1 on the cycle after the edge, saturating at 0.
  - Simultaneous P1/P2 hits decrement both in the same cycle.
- Timer:
  - In FIGHT, frame_tick increments the tick counter.
  - At TICKS_PER_SEC-1 the tick counter wraps to 0 and round_timer decrements, saturating at 0.
- ko_cond = (player1_health==0) | (player2_health==0) | (round_timer==0), evaluated on registered values.
- IDLE: start -> INTRO.
- INTRO:
  - On entry: healths=HEALTH_MAX, round_timer=ROUND_TIME, tick counter=0.
  - Counts frame_ticks; after INTRO_FRAMES ticks -> FIGHT.
- FIGHT: ko_cond -> KO. On that same cycle round_winner is latched by comparing healths:
  - P1 higher -> 1, and player1_rounds increments.
  - P2 higher -> 2, and player2_rounds increments.
  - Equal (includes double KO) -> 3, and no round is awarded.
  - Hit edges on the transition cycle are discarded.
- KO: after KO_FRAMES ticks:
  - either rounds counter == ROUNDS_TO_WIN -> MATCH_OVER, with match_winner set accordingly;
  - otherwise -> INTRO.
- MATCH_OVER: holds all outputs. start -> INTRO, with rounds cleared, round_winner=0 and match_winner=0.
- start is ignored in INTRO, FIGHT and KO.
- Reset asserted mid-operation returns everything to reset values immediately.
- Frame counter: shared, cleared on every phase change; it only advances on frame_tick.

Decomposition:
- Shared package (game_pkg):
  - phase encodings
  - S_HITSTUN=4'd9
  - round_winner/match_winner codes
- One natural sub-module, hit_edge_detect: registered rising-edge detector on the hitstun compare, instantiated once per player.
- Health saturating-decrement logic and the FSM stay in match_controller.

Test Plan:
- Reset then start; after 90 frame_ticks: phase=2, fight_enable=1, healths=3/3, round_timer=99.
- In FIGHT, three separate P2 hitstun entries:
  - player2_health goes 3->2->1->0, one cycle after each edge.
  - Next cycle: phase=3, round_winner=1, player1_rounds=1.
- player1_state held at 9 through INTRO into FIGHT -> no decrement. A later exit and re-entry -> health 2.
- Simultaneous P1/P2 hitstun edges at health 1/1 -> both reach 0, round_winner=3, and neither rounds counter changes.
- 99*60 frame_ticks with no hits and healths 3/2:
  - round_timer reaches 0.
  - KO with round_winner=1.
- P1 wins two rounds -> after KO_FRAMES: phase=4, match_winner=1. start -> rounds=0/0, phase=1. rst low mid-FIGHT -> all outputs at reset values.
